// File: rtl/banked_data_memory_if.sv
// Request/response bus between the core's MEM stage and banked_data_memory.
// The master drives the request fields; the slave (the memory) answers with a
// one-cycle response and keeps the fault bookkeeping outputs visible.
interface banked_data_memory_if #(
    parameter int COUNT_WIDTH = 8
);
    logic                   req_valid_in;
    logic                   req_ready_out;
    logic [31:0]            addr_in;
    logic                   we_in;
    logic [1:0]             size_in;
    logic                   signed_in;
    logic [31:0]            writedata_in;
    logic                   resp_valid_out;
    logic [31:0]            readdata_out;
    logic                   fault_out;
    logic [31:0]            fault_addr_out;
    logic [COUNT_WIDTH-1:0] fault_count_out;

    modport master (
        output req_valid_in, addr_in, we_in, size_in, signed_in, writedata_in,
        input  req_ready_out, resp_valid_out, readdata_out, fault_out,
               fault_addr_out, fault_count_out
    );

    modport slave (
        input  req_valid_in, addr_in, we_in, size_in, signed_in, writedata_in,
        output req_ready_out, resp_valid_out, readdata_out, fault_out,
               fault_addr_out, fault_count_out
    );
endinterface

// File: rtl/banked_data_memory.sv
// Banked data memory for the MIPS core: NUM_REGIONS RAM regions selected by a
// 16-bit tag on addr[31:16], byte/half/word access with sign or zero extension,
// and fault detection (unmapped, reserved size, misaligned) with a sticky
// fault address and a saturating fault counter. One access every two cycles;
// the response is presented the cycle after acceptance.
module banked_data_memory #(
    parameter int                        NUM_REGIONS = 2,
    parameter logic [16*NUM_REGIONS-1:0] REGION_TAGS = {16'h7fff, 16'h1000},
    parameter int                        DEPTH_WORDS = 1024,
    parameter int                        COUNT_WIDTH = 8
) (
    input logic                 clock,
    input logic                 reset,
    banked_data_memory_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int RGN_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_RSVD = 2'b10,
        SZ_WORD = 2'b11
    } size_e;

    // Storage: one word array per region.
    logic [31:0]            r_mem [NUM_REGIONS][DEPTH_WORDS];

    // Control state.
    state_e                 r_state;
    state_e                 w_state_next;
    logic                   r_fault;
    logic                   r_zero;
    logic [1:0]             r_offset;
    size_e                  r_size;
    logic                   r_signed;
    logic [31:0]            r_read_word;
    logic [31:0]            r_fault_addr;
    logic [COUNT_WIDTH-1:0] r_fault_count;

    // Request decode.
    size_e                  w_size;
    logic                   w_hit;
    logic [RGN_W-1:0]       w_region;
    logic [IDX_W-1:0]       w_index;
    logic                   w_misaligned;
    logic                   w_reserved;
    logic                   w_fault;
    logic                   w_accept;
    logic [3:0]             w_be;
    logic [31:0]            w_wdata_lanes;

    // Load formatting.
    logic [7:0]             w_lane_byte;
    logic [15:0]            w_lane_half;
    logic [31:0]            w_load_data;

    // Offset bits above the word index are intentionally ignored (wrap).
    logic                   w_unused_addr;
    assign w_unused_addr = ^bus.addr_in;

    assign w_size   = size_e'(bus.size_in);
    assign w_index  = bus.addr_in[2 +: IDX_W];
    assign w_accept = (r_state == ST_IDLE) && bus.req_valid_in;

    // Region decode: scanning from the top down lets the lowest matching index win.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_hit    = 1'b0;
        w_region = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (bus.addr_in[31:16] == REGION_TAGS[16*i +: 16]) begin
                w_hit    = 1'b1;
                w_region = RGN_W'(i);
            end
        end
    end

    // Fault classification: reserved size and alignment per access width.
    always_comb begin
        w_misaligned = 1'b0;
        w_reserved   = 1'b0;
        case (w_size)
            SZ_BYTE: w_misaligned = 1'b0;
            SZ_HALF: w_misaligned = bus.addr_in[0];
            SZ_WORD: w_misaligned = |bus.addr_in[1:0];
            default: w_reserved   = 1'b1;
        endcase
        w_fault = !w_hit || w_reserved || w_misaligned;
    end

    // Store lane steering: replicate the right-aligned data and pick byte enables.
    always_comb begin
        w_be          = 4'b0000;
        w_wdata_lanes = bus.writedata_in;
        case (w_size)
            SZ_BYTE: begin
                w_be          = 4'b0001 << bus.addr_in[1:0];
                w_wdata_lanes = {4{bus.writedata_in[7:0]}};
            end
            SZ_HALF: begin
                w_be          = bus.addr_in[1] ? 4'b1100 : 4'b0011;
                w_wdata_lanes = {2{bus.writedata_in[15:0]}};
            end
            SZ_WORD: w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // RAM port: byte-enabled write or registered word read at the accept edge.
    always_ff @(posedge clock) begin
        // NOTE: RAM contents carry no reset so the array maps onto plain block RAM.
        if (reset && w_accept && !w_fault) begin
            if (bus.we_in) begin
                for (int l = 0; l < 4; l++) begin
                    if (w_be[l]) begin
                        r_mem[w_region][w_index][8*l +: 8] <= w_wdata_lanes[8*l +: 8];
                    end
                end
            end else begin
                r_read_word <= r_mem[w_region][w_index];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and handshake outputs.
    always_comb begin
        w_state_next       = r_state;
        bus.req_ready_out  = 1'b0;
        bus.resp_valid_out = 1'b0;
        bus.fault_out      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.req_ready_out = 1'b1;
                if (bus.req_valid_in) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.resp_valid_out = 1'b1;
                bus.fault_out      = r_fault;
                w_state_next       = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Capture per-access response attributes at acceptance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fault  <= 1'b0;
            r_zero   <= 1'b1;
            r_offset <= 2'b00;
            r_size   <= SZ_WORD;
            r_signed <= 1'b0;
        end else if (w_accept) begin
            r_fault  <= w_fault;
            r_zero   <= w_fault || bus.we_in;
            r_offset <= bus.addr_in[1:0];
            r_size   <= w_size;
            r_signed <= bus.signed_in;
        end
    end

    // Fault address and saturating fault counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fault_addr  <= 32'h0;
            r_fault_count <= '0;
        end else if (w_accept && w_fault) begin
            r_fault_addr <= bus.addr_in;
            if (r_fault_count != '1) begin
                r_fault_count <= r_fault_count + 1'b1;
            end
        end
    end

    // Load formatting: shift the selected lane to bit 0 and extend.
    always_comb begin
        w_lane_byte = r_read_word[7:0];
        case (r_offset)
            2'd0:    w_lane_byte = r_read_word[7:0];
            2'd1:    w_lane_byte = r_read_word[15:8];
            2'd2:    w_lane_byte = r_read_word[23:16];
            default: w_lane_byte = r_read_word[31:24];
        endcase
        w_lane_half = r_offset[1] ? r_read_word[31:16] : r_read_word[15:0];
        case (r_size)
            SZ_BYTE: w_load_data = {{24{r_signed & w_lane_byte[7]}}, w_lane_byte};
            SZ_HALF: w_load_data = {{16{r_signed & w_lane_half[15]}}, w_lane_half};
            default: w_load_data = r_read_word;
        endcase
    end

    // Stores and faults answer with zero; attributes hold until the next accept.
    assign bus.readdata_out    = r_zero ? 32'h0 : w_load_data;
    assign bus.fault_addr_out  = r_fault_addr;
    assign bus.fault_count_out = r_fault_count;

endmodule

// File: tb/tb_banked_data_memory.sv
// Self-checking bench for banked_data_memory: directed scenarios followed by
// randomized traffic, all compared against a byte-level reference model.
module tb_banked_data_memory;

    logic clock = 1'b0;
    logic reset = 1'b0;

    int checks = 0;
    int errors = 0;

    banked_data_memory_if #(.COUNT_WIDTH(8)) bus ();

    banked_data_memory #(
        .NUM_REGIONS (2),
        .REGION_TAGS ({16'h7fff, 16'h1000}),
        .DEPTH_WORDS (1024),
        .COUNT_WIDTH (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Reference model: bytes keyed by region*4096 + byte offset (4 KB regions).
    logic [7:0]  model_mem [int];
    int unsigned exp_count;
    logic [31:0] exp_fault_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int region_of(input logic [15:0] tag);
        if (tag == 16'h1000) return 0;
        if (tag == 16'h7fff) return 1;
        return -1;
    endfunction

    // Model lookup of a load; known=0 when any byte was never written.
    function automatic logic [31:0] model_load(input logic [31:0] addr, input int nbytes,
                                               input logic sgn, output bit known);
        logic [31:0] v;
        int          base;
        v     = 32'h0;
        known = 1'b1;
        base  = region_of(addr[31:16]) * 4096 + int'(addr[11:0]);
        for (int b = nbytes - 1; b >= 0; b--) begin
            if (!model_mem.exists(base + b)) known = 1'b0;
            else v = (v << 8) | 32'(model_mem[base + b]);
        end
        if (sgn && nbytes < 4 && v[8*nbytes-1]) v = v | (32'hffff_ffff << (8*nbytes));
        return v;
    endfunction

    // One full access starting at a negedge in IDLE; returns the response data.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                             input logic sgn, input logic [31:0] wdata, output logic [31:0] rd);
        int          nbytes;
        int          base;
        bit          fault;
        bit          known;
        logic [31:0] exp_rd;
        nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        fault  = (region_of(addr[31:16]) < 0) || (size == 2'b10) || ((addr % nbytes) != 0);
        known  = 1'b1;
        exp_rd = 32'h0;
        if (!fault && !we) exp_rd = model_load(addr, nbytes, sgn, known);

        check("ready_idle", 32'(bus.req_ready_out), 32'd1);
        bus.req_valid_in = 1'b1;
        bus.addr_in      = addr;
        bus.we_in        = we;
        bus.size_in      = size;
        bus.signed_in    = sgn;
        bus.writedata_in = wdata;
        @(posedge clock);

        if (fault) begin
            exp_fault_addr = addr;
            if (exp_count < 255) exp_count++;
        end else if (we) begin
            base = region_of(addr[31:16]) * 4096 + int'(addr[11:0]);
            for (int b = 0; b < nbytes; b++) model_mem[base + b] = wdata[8*b +: 8];
        end

        @(negedge clock);
        check("resp_valid", 32'(bus.resp_valid_out), 32'd1);
        check("ready_resp", 32'(bus.req_ready_out), 32'd0);
        check("fault_out", 32'(bus.fault_out), 32'(fault));
        if (known) check("readdata", bus.readdata_out, exp_rd);
        check("fault_addr", bus.fault_addr_out, exp_fault_addr);
        check("fault_count", 32'(bus.fault_count_out), exp_count);
        rd = bus.readdata_out;

        // Garbage during RESP, with valid still high, must be ignored.
        bus.addr_in      = $urandom;
        bus.we_in        = 1'b1;
        bus.size_in      = 2'(($urandom));
        bus.writedata_in = $urandom;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid_in = 1'b0;
        check("resp_drop", 32'(bus.resp_valid_out), 32'd0);
        if (known) check("readdata_hold", bus.readdata_out, exp_rd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired got=0x%08h exp=0x%08h", 32'd0, 32'd1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] addr;
        logic [15:0] tag;
        bit          known;
        logic [31:0] exp_rd;

        exp_count        = 0;
        exp_fault_addr   = 32'h0;
        bus.req_valid_in = 1'b0;
        bus.addr_in      = 32'h0;
        bus.we_in        = 1'b0;
        bus.size_in      = 2'b11;
        bus.signed_in    = 1'b0;
        bus.writedata_in = 32'h0;

        // Reset state.
        #12;
        check("rst_ready", 32'(bus.req_ready_out), 32'd1);
        check("rst_resp", 32'(bus.resp_valid_out), 32'd0);
        check("rst_rdata", bus.readdata_out, 32'h0);
        check("rst_fault", 32'(bus.fault_out), 32'd0);
        check("rst_faddr", bus.fault_addr_out, 32'h0);
        check("rst_fcount", 32'(bus.fault_count_out), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Word store/load round trip.
        do_access(1'b1, 32'h1000_0004, 2'b11, 1'b0, 32'hDEAD_BEEF, rd);
        check("store_ack_zero", rd, 32'h0);
        do_access(1'b0, 32'h1000_0004, 2'b11, 1'b0, 32'h0, rd);
        check("word_load", rd, 32'hDEAD_BEEF);

        // Byte loads of the top lane, signed and unsigned.
        do_access(1'b0, 32'h1000_0007, 2'b00, 1'b1, 32'h0, rd);
        check("byte_signed", rd, 32'hFFFF_FFDE);
        do_access(1'b0, 32'h1000_0007, 2'b00, 1'b0, 32'h0, rd);
        check("byte_unsigned", rd, 32'h0000_00DE);
        do_access(1'b0, 32'h1000_0006, 2'b01, 1'b1, 32'h0, rd);
        check("half_signed", rd, 32'hFFFF_DEAD);

        // Half store into the upper lanes of a filled word.
        do_access(1'b1, 32'h7fff_0000, 2'b11, 1'b0, 32'hAAAA_AAAA, rd);
        do_access(1'b1, 32'h7fff_0002, 2'b01, 1'b0, 32'h5555_1234, rd);
        do_access(1'b0, 32'h7fff_0000, 2'b11, 1'b0, 32'h0, rd);
        check("half_merge", rd, 32'h1234_AAAA);

        // Misaligned load and unmapped store both fault; RAM untouched.
        do_access(1'b0, 32'h1000_0002, 2'b11, 1'b0, 32'h0, rd);
        do_access(1'b1, 32'h2000_0000, 2'b11, 1'b0, 32'h1111_1111, rd);
        check("faults_addr", bus.fault_addr_out, 32'h2000_0000);
        check("faults_count", 32'(bus.fault_count_out), 32'd2);
        do_access(1'b1, 32'h1000_0006, 2'b11, 1'b0, 32'h0000_0000, rd);
        do_access(1'b1, 32'h1000_0004, 2'b10, 1'b0, 32'h0000_0000, rd);
        do_access(1'b0, 32'h1000_0004, 2'b11, 1'b0, 32'h0, rd);
        check("ram_unchanged", rd, 32'hDEAD_BEEF);

        // Offset bits above the region size wrap.
        do_access(1'b1, 32'h1000_1000, 2'b00, 1'b0, 32'h0000_0055, rd);
        do_access(1'b0, 32'h1000_0000, 2'b00, 1'b0, 32'h0, rd);
        check("wrap_byte", rd, 32'h0000_0055);

        // Fill a 64-byte window in each region so random loads are predictable.
        for (int r = 0; r < 2; r++) begin
            for (int w = 0; w < 16; w++) begin
                tag = (r == 0) ? 16'h1000 : 16'h7fff;
                do_access(1'b1, {tag, 16'(w * 4)}, 2'b11, 1'b0, $urandom, rd);
            end
        end

        // Valid held high: ready and resp alternate, one access per two cycles.
        exp_rd = model_load(32'h1000_0004, 4, 1'b0, known);
        bus.req_valid_in = 1'b1;
        bus.addr_in      = 32'h1000_0004;
        bus.we_in        = 1'b0;
        bus.size_in      = 2'b11;
        bus.signed_in    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("stream_ready", 32'(bus.req_ready_out), 32'((i % 2) == 0));
            check("stream_resp", 32'(bus.resp_valid_out), 32'((i % 2) == 1));
            if ((i % 2) == 1) check("stream_data", bus.readdata_out, exp_rd);
            @(posedge clock);
            @(negedge clock);
        end
        bus.req_valid_in = 1'b0;

        // Randomized traffic: mapped/unmapped tags, all sizes, wrapping offsets.
        for (int n = 0; n < 700; n++) begin
            case ($urandom_range(0, 3))
                0:       tag = 16'h1000;
                1:       tag = 16'h7fff;
                2:       tag = 16'h2000;
                default: tag = 16'($urandom);
            endcase
            addr = {tag, 4'($urandom_range(0, 15)), 12'($urandom_range(0, 63))};
            do_access(1'($urandom), addr, 2'($urandom_range(0, 3)), 1'($urandom), $urandom, rd);
        end
        check("count_saturated", 32'(bus.fault_count_out), 32'(exp_count));

        // Reset during RESP drops the response but keeps the accepted store.
        bus.req_valid_in = 1'b1;
        bus.addr_in      = 32'h7fff_0010;
        bus.we_in        = 1'b1;
        bus.size_in      = 2'b11;
        bus.writedata_in = 32'hCAFE_F00D;
        @(posedge clock);
        @(negedge clock);
        check("pre_rst_resp", 32'(bus.resp_valid_out), 32'd1);
        reset = 1'b0;
        #1;
        bus.req_valid_in = 1'b0;
        check("midrst_resp", 32'(bus.resp_valid_out), 32'd0);
        check("midrst_count", 32'(bus.fault_count_out), 32'd0);
        check("midrst_faddr", bus.fault_addr_out, 32'h0);
        check("midrst_ready", 32'(bus.req_ready_out), 32'd1);
        check("midrst_rdata", bus.readdata_out, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        exp_count      = 0;
        exp_fault_addr = 32'h0;
        for (int b = 0; b < 4; b++) model_mem[4096 + 16 + b] = 8'(32'hCAFE_F00D >> (8*b));
        @(negedge clock);
        do_access(1'b0, 32'h7fff_0010, 2'b11, 1'b0, 32'h0, rd);
        check("store_survives_rst", rd, 32'hCAFE_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
